// File: rtl/trig_seq_pkg.sv
// rtl/trig_seq_pkg.sv - shared constants, gate FSM states and mV scaling helper for trig_sequencer
//
// Purpose : default thresholds/levels in millivolts, the gate FSM state type and
//           the millivolt-to-counts conversion used by every CV comparison.
// Ports   : none (package).

package trig_seq_pkg;

    localparam int DEF_FP_OFFSET    = 2;
    localparam int DEF_THRESH_HI_MV = 1000;
    localparam int DEF_THRESH_LO_MV = 500;
    localparam int DEF_GATE_MV      = 5000;
    localparam int DEF_STEP_MV      = 250;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        GAP  = 2'd2
    } gate_state_t;

    // Millivolts to sample counts: counts = mV <<< fp_offset.
    function automatic int from_mv(input int mv, input int fp_offset);
        return mv <<< fp_offset;
    endfunction

endpackage

// File: rtl/schmitt_edge.sv
// rtl/schmitt_edge.sv - Schmitt-trigger CV conditioner with registered state and rising-edge flag
//
// Purpose : turns a noisy CV into a clean logic level with hysteresis and flags
//           the cycle after the level goes 0->1.
// Ports   : clk   - sample clock
//           rst   - synchronous active-high reset
//           in    - signed CV sample, W bits
//           state - registered Schmitt level
//           rise  - high for one cycle after state goes 0->1

module schmitt_edge #(
    parameter int                  W  = 16,
    parameter logic signed [W-1:0] HI = '0,
    parameter logic signed [W-1:0] LO = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in,
    output logic                state,
    output logic                rise
);

    logic state_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            prev_q <= state_q;
            if (in >= HI) begin
                state_q <= 1'b1;
            end else if (in < LO) begin
                state_q <= 1'b0;
            end
        end
    end

    assign state = state_q;
    // Both operands are registers, so the edge is consumed one edge after the level was captured.
    assign rise  = state_q & ~prev_q;

endmodule

// File: rtl/trig_sequencer.sv
// rtl/trig_sequencer.sv - pattern-driven trigger sequencer with fixed-width gate output
//
// Purpose : steps an N-step on/off pattern on each clock-CV edge and emits a
//           GATE_SAMPLES-wide gate on every active step, with a one-sample low gap
//           on retrigger so the downstream sampler re-arms.
// Ports   : sample_clk  - sole clock, one edge per audio sample
//           rst         - synchronous active-high reset
//           sample_in0  - clock CV
//           sample_in1  - pattern-restart CV
//           sample_in2  - pattern select CV (high selects PATTERN_B)
//           sample_in3  - passthrough
//           sample_out0 - trigger gate (0 or GATE_MV)
//           sample_out1 - GATE_MV while on step 0, else 0
//           sample_out2 - step CV, step_idx * STEP_MV
//           sample_out3 - sample_in3, combinational

module trig_sequencer
    import trig_seq_pkg::*;
#(
    parameter int          W            = 16,
    parameter int          FP_OFFSET    = DEF_FP_OFFSET,
    parameter int          N_STEPS      = 16,
    parameter logic [31:0] PATTERN_A    = 32'h0000_8888,
    parameter logic [31:0] PATTERN_B    = 32'h0000_AAAA,
    parameter int          GATE_SAMPLES = 480,
    parameter int          THRESH_HI_MV = DEF_THRESH_HI_MV,
    parameter int          THRESH_LO_MV = DEF_THRESH_LO_MV,
    parameter int          GATE_MV      = DEF_GATE_MV,
    parameter int          STEP_MV      = DEF_STEP_MV
) (
    input  logic                sample_clk,
    input  logic                rst,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3
);

    localparam int STEP_W = $clog2(N_STEPS);
    localparam int CNT_W  = $clog2(GATE_SAMPLES + 1);

    localparam logic signed [W-1:0] HI_CNT     = W'(from_mv(THRESH_HI_MV, FP_OFFSET));
    localparam logic signed [W-1:0] LO_CNT     = W'(from_mv(THRESH_LO_MV, FP_OFFSET));
    localparam logic signed [W-1:0] GATE_CNT   = W'(from_mv(GATE_MV, FP_OFFSET));
    localparam logic        [W-1:0] STEP_CNT   = W'(from_mv(STEP_MV, FP_OFFSET));
    localparam logic   [STEP_W-1:0] LAST_STEP  = STEP_W'(N_STEPS - 1);
    localparam logic    [CNT_W-1:0] CNT_RELOAD = CNT_W'(GATE_SAMPLES - 1);

    // Elaboration-time parameter checks.
    if (N_STEPS < 2 || N_STEPS > 32) begin : g_bad_n_steps
        $error("trig_sequencer: N_STEPS must be in 2..32");
    end
    if (GATE_SAMPLES < 1) begin : g_bad_gate_samples
        $error("trig_sequencer: GATE_SAMPLES must be at least 1");
    end
    if (from_mv(N_STEPS * STEP_MV, FP_OFFSET) >= (1 <<< (W - 1))) begin : g_bad_step_range
        $error("trig_sequencer: N_STEPS*STEP_MV does not fit in W-1 bits");
    end

    // CV conditioning
    logic clk_state, clk_rise;
    logic rst_state, rst_rise;
    logic sel_state, sel_rise;

    schmitt_edge #(.W(W), .HI(HI_CNT), .LO(LO_CNT)) u_clk_cv (
        .clk   (sample_clk),
        .rst   (rst),
        .in    (sample_in0),
        .state (clk_state),
        .rise  (clk_rise)
    );

    schmitt_edge #(.W(W), .HI(HI_CNT), .LO(LO_CNT)) u_restart_cv (
        .clk   (sample_clk),
        .rst   (rst),
        .in    (sample_in1),
        .state (rst_state),
        .rise  (rst_rise)
    );

    schmitt_edge #(.W(W), .HI(HI_CNT), .LO(LO_CNT)) u_select_cv (
        .clk   (sample_clk),
        .rst   (rst),
        .in    (sample_in2),
        .state (sel_state),
        .rise  (sel_rise)
    );

    // Levels of the clock/restart inputs and the edge of the select input have no consumer.
    logic unused_cv_bits;
    assign unused_cv_bits = clk_state ^ rst_state ^ sel_rise;

    // Step counter
    logic [STEP_W-1:0] step_idx, step_nxt;
    logic              armed, armed_nxt;
    logic       [31:0] pattern;
    logic              fire;

    always_comb begin
        step_nxt  = step_idx;
        armed_nxt = armed;
        if (rst_rise) begin
            // Restart beats advance; a coincident clock edge consumes the arm so step 0 plays now.
            step_nxt  = '0;
            armed_nxt = ~clk_rise;
        end else if (clk_rise) begin
            if (armed) begin
                armed_nxt = 1'b0;
            end else if (step_idx == LAST_STEP) begin
                step_nxt = '0;
            end else begin
                step_nxt = step_idx + STEP_W'(1);
            end
        end
        pattern = sel_state ? PATTERN_B : PATTERN_A;
        fire    = clk_rise & pattern[step_nxt];
    end

    // Gate FSM
    gate_state_t      gate_state, gate_nxt;
    logic [CNT_W-1:0] gate_cnt, cnt_nxt;

    always_comb begin
        gate_nxt = gate_state;
        cnt_nxt  = gate_cnt;
        case (gate_state)
            IDLE: begin
                if (fire) begin
                    gate_nxt = GATE;
                    cnt_nxt  = CNT_RELOAD;
                end
            end
            GATE: begin
                if (fire) begin
                    gate_nxt = GAP;
                end else if (gate_cnt == '0) begin
                    gate_nxt = IDLE;
                end else begin
                    cnt_nxt = gate_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                // A fire seen here is absorbed: the low sample is always exactly one cycle.
                gate_nxt = GATE;
                cnt_nxt  = CNT_RELOAD;
            end
            default: begin
                gate_nxt = IDLE;
                cnt_nxt  = '0;
            end
        endcase
    end

    // Output values, registered alongside the state they describe
    logic signed [W-1:0] out0_nxt, out1_nxt, out2_nxt;

    always_comb begin
        out0_nxt = (gate_nxt == GATE) ? GATE_CNT : '0;
        out1_nxt = (step_nxt == '0) ? GATE_CNT : '0;
        out2_nxt = W'(step_nxt) * STEP_CNT;
    end

    always_ff @(posedge sample_clk) begin
        if (rst) begin
            step_idx    <= '0;
            armed       <= 1'b1;
            gate_state  <= IDLE;
            gate_cnt    <= '0;
            sample_out0 <= '0;
            sample_out1 <= '0;
            sample_out2 <= '0;
        end else begin
            step_idx    <= step_nxt;
            armed       <= armed_nxt;
            gate_state  <= gate_nxt;
            gate_cnt    <= cnt_nxt;
            sample_out0 <= out0_nxt;
            sample_out1 <= out1_nxt;
            sample_out2 <= out2_nxt;
        end
    end

    assign sample_out3 = sample_in3;

endmodule

// File: tb/tb_trig_sequencer.sv
// tb/tb_trig_sequencer.sv - self-checking bench for trig_sequencer (two configurations, shared stimulus)

module tb_trig_sequencer;

    logic sample_clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic signed [15:0] d_out0 [2];
    logic signed [15:0] d_out1 [2];
    logic signed [15:0] d_out2 [2];
    logic signed [15:0] d_out3 [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sample_clk = ~sample_clk;

    // dut0: sparse pattern, short gate. dut1: all-ones pattern, long gate for retriggers.
    trig_sequencer #(.PATTERN_A(32'h0000_0005), .PATTERN_B(32'h0000_0002), .GATE_SAMPLES(4)) dut0 (
        .sample_clk (sample_clk), .rst (rst),
        .sample_in0 (in0), .sample_in1 (in1), .sample_in2 (in2), .sample_in3 (in3),
        .sample_out0 (d_out0[0]), .sample_out1 (d_out1[0]),
        .sample_out2 (d_out2[0]), .sample_out3 (d_out3[0])
    );

    trig_sequencer #(.PATTERN_A(32'hFFFF_FFFF), .PATTERN_B(32'h0000_0002), .GATE_SAMPLES(30)) dut1 (
        .sample_clk (sample_clk), .rst (rst),
        .sample_in0 (in0), .sample_in1 (in1), .sample_in2 (in2), .sample_in3 (in3),
        .sample_out0 (d_out0[1]), .sample_out1 (d_out1[1]),
        .sample_out2 (d_out2[1]), .sample_out3 (d_out3[1])
    );

    task automatic chk(input string name, input int idx, input logic signed [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_gs [2];
    logic [31:0] m_pa [2];
    logic [31:0] m_pb [2];
    bit  h0_1, h0_2, h1_1, h1_2, h2_1, h2_2;  // Schmitt level after last edge / edge before
    int  m_step [2];
    bit  m_armed [2];
    int  m_mode [2];   // 0 low-idle, 1 high, 2 forced-low gap
    int  m_left [2];   // high samples still to show, counting the current one
    int  e0 [2], e1 [2], e2 [2];
    bit  mvalid = 1'b0;

    initial begin
        m_gs[0] = 4;  m_pa[0] = 32'h0000_0005; m_pb[0] = 32'h0000_0002;
        m_gs[1] = 30; m_pa[1] = 32'hFFFF_FFFF; m_pb[1] = 32'h0000_0002;
    end

    function automatic bit schmitt(input int v, input bit prev);
        if (v >= 4000) return 1'b1;
        if (v < 2000)  return 1'b0;
        return prev;
    endfunction

    always @(posedge sample_clk) begin : model
        bit r0, r1, sel, fire;
        if (rst) begin
            h0_1 = 0; h0_2 = 0; h1_1 = 0; h1_2 = 0; h2_1 = 0; h2_2 = 0;
            for (int i = 0; i < 2; i++) begin
                m_step[i] = 0; m_armed[i] = 1; m_mode[i] = 0; m_left[i] = 0;
                e0[i] = 0; e1[i] = 0; e2[i] = 0;
            end
            mvalid = 1'b1;
        end else begin
            r0  = h0_1 && !h0_2;
            r1  = h1_1 && !h1_2;
            sel = h2_1;
            for (int i = 0; i < 2; i++) begin
                if (r1) begin
                    m_step[i]  = 0;
                    m_armed[i] = !r0;
                end else if (r0) begin
                    if (m_armed[i]) m_armed[i] = 0;
                    else m_step[i] = (m_step[i] + 1) % 16;
                end
                fire = r0 && (sel ? m_pb[i][m_step[i]] : m_pa[i][m_step[i]]);
                case (m_mode[i])
                    0: if (fire) begin m_mode[i] = 1; m_left[i] = m_gs[i]; end
                    1: begin
                        if (fire) m_mode[i] = 2;
                        else begin
                            m_left[i] = m_left[i] - 1;
                            if (m_left[i] == 0) m_mode[i] = 0;
                        end
                    end
                    default: begin m_mode[i] = 1; m_left[i] = m_gs[i]; end
                endcase
                e0[i] = (m_mode[i] == 1) ? 20000 : 0;
                e1[i] = (m_step[i] == 0) ? 20000 : 0;
                e2[i] = m_step[i] * 1000;
            end
            h0_2 = h0_1; h0_1 = schmitt(int'(in0), h0_1);
            h1_2 = h1_1; h1_1 = schmitt(int'(in1), h1_1);
            h2_2 = h2_1; h2_1 = schmitt(int'(in2), h2_1);
        end
    end

    // ---------------- per-cycle compare ----------------
    always begin
        @(posedge sample_clk);
        #2;
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                chk("out0", i, d_out0[i], e0[i]);
                chk("out1", i, d_out1[i], e1[i]);
                chk("out2", i, d_out2[i], e2[i]);
                chk("out3", i, d_out3[i], int'(in3));
            end
        end
    end

    initial forever begin
        @(negedge sample_clk);
        in3 = in3 + 16'sd1237;
    end

    // ---------------- stimulus ----------------
    task automatic rise_inputs(input bit c, input bit r);
        @(negedge sample_clk);
        if (c) in0 = 16'sd4000;
        if (r) in1 = 16'sd4000;
        @(posedge sample_clk);
        @(posedge sample_clk);
        #2;
    endtask

    task automatic fall_inputs(input int hold, input int lo);
        repeat (hold) @(negedge sample_clk);
        in0 = '0;
        in1 = '0;
        repeat (lo) @(negedge sample_clk);
    endtask

    initial begin
        repeat (3) @(negedge sample_clk);
        chk("lit_rst_out0", 0, d_out0[0], 0);
        chk("lit_rst_out1", 0, d_out1[0], 0);
        chk("lit_rst_out2", 1, d_out2[1], 0);
        rst = 1'b0;
        @(posedge sample_clk); #2;
        chk("lit_out1_after_rst", 0, d_out1[0], 20000);
        repeat (5) @(negedge sample_clk);

        // First edge after reset plays step 0; 4-sample gate on dut0.
        rise_inputs(1, 0);
        chk("lit_first_gate", 0, d_out0[0], 20000);
        chk("lit_first_out2", 0, d_out2[0], 0);
        chk("lit_first_out1", 0, d_out1[0], 20000);
        chk("lit_first_gate", 1, d_out0[1], 20000);
        for (int k = 1; k <= 3; k++) begin
            @(posedge sample_clk); #2;
            chk("lit_gate_hold", 0, d_out0[0], 20000);
        end
        @(posedge sample_clk); #2;
        chk("lit_gate_end", 0, d_out0[0], 0);
        fall_inputs(4, 10);

        // Steps 1..3, period 20: dut0 fires on step 2 only; dut1 retriggers into a gap.
        for (int k = 1; k <= 3; k++) begin
            rise_inputs(1, 0);
            chk("lit_step_out2", 0, d_out2[0], k * 1000);
            chk("lit_step_gate", 0, d_out0[0], (k == 2) ? 20000 : 0);
            chk("lit_step_gap", 1, d_out0[1], 0);
            fall_inputs(8, 10);
        end

        // Hysteresis: hovering between thresholds never produces a new edge.
        rise_inputs(1, 0);
        chk("lit_step4_out2", 0, d_out2[0], 4000);
        chk("lit_step4_gate", 0, d_out0[0], 0);
        @(negedge sample_clk); in0 = 16'sd3000;
        repeat (5) @(negedge sample_clk); in0 = 16'sd4000;
        repeat (4) @(negedge sample_clk); in0 = 16'sd2000;
        repeat (4) @(negedge sample_clk); in0 = 16'sd4000;
        repeat (4) @(negedge sample_clk);
        @(posedge sample_clk); #2;
        chk("lit_hover_hold", 0, d_out2[0], 4000);
        @(negedge sample_clk); in0 = 16'sd1000;
        repeat (3) @(negedge sample_clk); in0 = 16'sd3999;
        repeat (4) @(negedge sample_clk);
        @(posedge sample_clk); #2;
        chk("lit_below_hi", 0, d_out2[0], 4000);
        rise_inputs(1, 0);
        chk("lit_hover_release", 0, d_out2[0], 5000);
        fall_inputs(4, 10);

        // Retrigger on dut1 with period 10: one low gap sample, then high again.
        repeat (40) @(negedge sample_clk);
        rise_inputs(1, 0);
        chk("lit_retrig_start", 1, d_out0[1], 20000);
        chk("lit_step6_out2", 0, d_out2[0], 6000);
        fall_inputs(3, 5);
        rise_inputs(1, 0);
        chk("lit_retrig_gap", 1, d_out0[1], 0);
        @(posedge sample_clk); #2;
        chk("lit_retrig_after_gap", 1, d_out0[1], 20000);
        chk("lit_step7_out2", 0, d_out2[0], 7000);
        fall_inputs(2, 5);

        // Restart coincident with a clock edge at step 7 plays step 0 now.
        rise_inputs(1, 1);
        chk("lit_restart_clk_out2", 0, d_out2[0], 0);
        chk("lit_restart_clk_gate", 0, d_out0[0], 20000);
        chk("lit_restart_clk_out1", 0, d_out1[0], 20000);
        chk("lit_restart_clk_gap", 1, d_out0[1], 0);
        fall_inputs(3, 10);
        rise_inputs(1, 0);
        chk("lit_after_restart_step1", 0, d_out2[0], 1000);
        fall_inputs(3, 10);
        // Restart alone re-arms: the next clock edge plays step 0, not step 1.
        rise_inputs(0, 1);
        chk("lit_restart_only_out2", 0, d_out2[0], 0);
        chk("lit_restart_only_gate", 0, d_out0[0], 0);
        fall_inputs(3, 10);
        rise_inputs(1, 0);
        chk("lit_rearm_out2", 0, d_out2[0], 0);
        chk("lit_rearm_gate", 0, d_out0[0], 20000);
        fall_inputs(3, 10);

        // Pattern select: PATTERN_B fires on step 1 only.
        @(negedge sample_clk); in2 = 16'sd4000;
        repeat (3) @(negedge sample_clk);
        rise_inputs(1, 0);
        chk("lit_patb_step1", 0, d_out0[0], 20000);
        fall_inputs(3, 10);
        rise_inputs(1, 0);
        chk("lit_patb_step2", 0, d_out0[0], 0);
        chk("lit_patb_step2_out2", 0, d_out2[0], 2000);
        fall_inputs(3, 10);
        @(negedge sample_clk); in2 = '0;
        repeat (40) @(negedge sample_clk);

        // Reset mid-gate.
        rise_inputs(1, 0);
        chk("lit_step3_gate", 1, d_out0[1], 20000);
        chk("lit_step3_nogate", 0, d_out0[0], 0);
        @(posedge sample_clk); #2;
        chk("lit_mid_gate", 1, d_out0[1], 20000);
        @(negedge sample_clk); rst = 1'b1;
        @(posedge sample_clk); #2;
        chk("lit_rst_mid_gate", 1, d_out0[1], 0);
        chk("lit_rst_mid_out2", 1, d_out2[1], 0);
        chk("lit_rst_mid_out1", 0, d_out1[0], 0);
        @(negedge sample_clk); rst = 1'b0; in0 = '0;
        @(posedge sample_clk); #2;
        chk("lit_rst_release_out1", 0, d_out1[0], 20000);

        // Maximum edge rate and wrap: 18 edges from reset = arm + 17 advances -> step 1.
        repeat (3) @(negedge sample_clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge sample_clk); in0 = 16'sd4000;
            @(negedge sample_clk); in0 = '0;
        end
        repeat (3) @(negedge sample_clk);
        @(posedge sample_clk); #2;
        chk("lit_wrap_out2", 0, d_out2[0], 1000);

        repeat (5) @(negedge sample_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
